// File: rtl/dut_if_pkg.sv
// Shared definitions for the dut command issuer:
// op encoding, default widths, FSM states, command layout.
package dut_if_pkg;

   localparam int DEF_ADDR_W = 3;
   localparam int DEF_DATA_W = 1;

   localparam logic OP_WRITE = 1'b0;
   localparam logic OP_READ  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_HOLD_RSP
   } state_e;

   typedef struct packed {
      logic                  op;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] data;
   } cmd_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count.
// Head reads as zero while the FIFO is empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic                     full,
   output logic                     empty,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign count   = cnt_q;
   assign head    = empty ? '0 : mem_q[rptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (do_push) begin
         mem_d[wptr_q] = din;
         wptr_d        = wptr_q + AW'(1);
      end
      if (do_pop) begin
         rptr_d = rptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (!do_push && do_pop) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q  <= '{default: '0};
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/dut_cmd_issuer.sv
// Buffers write/read commands, issues them in order on the dut
// enable/ready ports and queues read results for the consumer.
module dut_cmd_issuer
   import dut_if_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int CMD_DEPTH = 4,
   parameter int RSP_DEPTH = 4,
   parameter int CNT_W     = 8
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] write_address,
   output logic [DATA_W-1:0] write_data,
   output logic              write_en,
   input  logic              write_rdy,
   output logic [ADDR_W-1:0] read_address,
   output logic              read_en,
   input  logic [DATA_W-1:0] read_data,
   input  logic              read_rdy,
   output logic              busy,
   output logic [CNT_W-1:0]  wr_count,
   output logic [CNT_W-1:0]  rd_count
);

   localparam int CMD_W  = 1 + ADDR_W + DATA_W;
   localparam int RSP_W  = ADDR_W + DATA_W;
   localparam int CMD_CW = $clog2(CMD_DEPTH) + 1;
   localparam int RSP_CW = $clog2(RSP_DEPTH) + 1;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   wr_count_q, wr_count_d;
   logic [CNT_W-1:0]   rd_count_q, rd_count_d;

   logic               cmd_push, cmd_pop;
   logic               cmd_full, cmd_empty;
   logic [CMD_W-1:0]   cmd_head;
   logic [CMD_CW-1:0]  cmd_count;
   logic               rsp_push, rsp_pop;
   logic               rsp_full, rsp_empty;
   logic [RSP_W-1:0]   rsp_head;
   logic [RSP_CW-1:0]  rsp_count;
   logic               rsp_unused;

   logic               head_op;
   logic [ADDR_W-1:0]  head_addr;
   logic [DATA_W-1:0]  head_data;
   logic               fire;
   logic               more;

   assign cmd_ready  = RST_N && !cmd_full;
   assign cmd_push   = cmd_valid && cmd_ready;
   assign rsp_valid  = !rsp_empty;
   assign rsp_pop    = rsp_valid && rsp_ready;
   assign rsp_addr   = rsp_head[RSP_W-1:DATA_W];
   assign rsp_data   = rsp_head[DATA_W-1:0];
   assign rsp_unused = ^rsp_count;

   assign head_op    = cmd_head[CMD_W-1];
   assign head_addr  = cmd_head[CMD_W-2:DATA_W];
   assign head_data  = cmd_head[DATA_W-1:0];

   // An entry pushed this cycle counts, so a burst keeps issuing.
   assign more     = (cmd_count > CMD_CW'(1)) || cmd_push;
   assign busy     = !cmd_empty || (state_q != ST_IDLE);
   assign wr_count = wr_count_q;
   assign rd_count = rd_count_q;

   sync_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_fifo (
      .clk   (CLK),
      .rst_n (RST_N),
      .push  (cmd_push),
      .pop   (cmd_pop),
      .din   ({cmd_op, cmd_addr, cmd_data}),
      .full  (cmd_full),
      .empty (cmd_empty),
      .head  (cmd_head),
      .count (cmd_count)
   );

   sync_fifo #(
      .WIDTH (RSP_W),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk   (CLK),
      .rst_n (RST_N),
      .push  (rsp_push),
      .pop   (rsp_pop),
      .din   ({head_addr, read_data}),
      .full  (rsp_full),
      .empty (rsp_empty),
      .head  (rsp_head),
      .count (rsp_count)
   );

   always_comb begin
      state_d       = state_q;
      wr_count_d    = wr_count_q;
      rd_count_d    = rd_count_q;
      write_en      = 1'b0;
      read_en       = 1'b0;
      write_address = '0;
      write_data    = '0;
      read_address  = '0;
      cmd_pop       = 1'b0;
      rsp_push      = 1'b0;
      fire          = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!cmd_empty || cmd_push) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            write_address = head_addr;
            write_data    = head_data;
            read_address  = head_addr;
            if (cmd_empty) begin
               state_d = ST_IDLE;
            end else begin
               unique case (head_op)
                  OP_WRITE: begin
                     write_en = write_rdy;
                     if (write_en) begin
                        fire       = 1'b1;
                        wr_count_d = wr_count_q + CNT_W'(1);
                     end
                  end
                  OP_READ: begin
                     if (rsp_full) begin
                        state_d = ST_HOLD_RSP;
                     end else begin
                        read_en = read_rdy;
                        if (read_en) begin
                           fire       = 1'b1;
                           rsp_push   = 1'b1;
                           rd_count_d = rd_count_q + CNT_W'(1);
                        end
                     end
                  end
               endcase
            end
            if (fire) begin
               cmd_pop = 1'b1;
               state_d = more ? ST_ISSUE : ST_IDLE;
            end
         end
         ST_HOLD_RSP: begin
            if (!rsp_full) state_d = ST_ISSUE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= ST_IDLE;
         wr_count_q <= '0;
         rd_count_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_count_q <= wr_count_d;
         rd_count_q <= rd_count_d;
      end
   end

endmodule
